spi_fifo_ctrl: RTL and testbench

- Sequencing controller for the SPI FIFO dual-port RAM. The RAM has a registered read with 1-cycle latency.
- Owns the write and read pointers, occupancy count, full/empty status and error flags.
- Presents a first-word-fall-through (FWFT) pop interface to the consumer, so the RAM read latency is hidden.
- One instance sits between each SPI shift engine and its FIFO RAM, on both the TX and RX paths.

---
 rtl/spi_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_spi_fifo_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo_ctrl.sv
// Sequencing controller for the SPI FIFO RAM: pointers, occupancy, FWFT pop and sticky error flags.
// Optional almostFull/almostEmpty registers are built when SPI_FIFO_LEVEL_FLAGS_EN is defined.
module spi_fifo_ctrl #(
   parameter int DATAWIDTH    = 8,
   parameter int DATADEPTH    = 1024,
   parameter int ADDRESSWIDTH = $clog2(DATADEPTH),
   parameter int AFULLLEVEL   = DATADEPTH - 2,
   parameter int AEMPTYLEVEL  = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    errClear,
   input  logic                    push,
   input  logic [DATAWIDTH-1:0]    pushData,
   input  logic                    pop,
   output logic [DATAWIDTH-1:0]    popData,
   output logic                    popValid,
   output logic                    full,
   output logic                    empty,
   output logic [ADDRESSWIDTH:0]   count,
   output logic                    overflow,
   output logic                    underflow,
   output logic                    memWriteEn,
   output logic [DATAWIDTH-1:0]    memDataIn,
   output logic [ADDRESSWIDTH-1:0] memWriteAddress,
   output logic [ADDRESSWIDTH-1:0] memReadAddress,
   input  logic [DATAWIDTH-1:0]    memDataOut
`ifdef SPI_FIFO_LEVEL_FLAGS_EN
   ,
   output logic                    almostFull,
   output logic                    almostEmpty
`endif
);

   localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(DATADEPTH - 1);
   localparam logic [ADDRESSWIDTH:0]   DEPTH_C   = (ADDRESSWIDTH + 1)'(DATADEPTH);

   if (DATADEPTH < 2 || AFULLLEVEL > DATADEPTH || AEMPTYLEVEL >= DATADEPTH) begin : g_bad_param
      $error("spi_fifo_ctrl: illegal depth or level parameters");
   end

   logic [ADDRESSWIDTH-1:0] wrPtr;
   logic [ADDRESSWIDTH-1:0] rdPtr;
   logic [ADDRESSWIDTH-1:0] wrPtrInc;
   logic [ADDRESSWIDTH-1:0] rdPtrInc;
   logic [ADDRESSWIDTH:0]   countAfterPop;
   logic [ADDRESSWIDTH:0]   countNext;
   logic                    hold;
   logic                    pushFire;
   logic                    popFire;

   always_comb begin
      hold          = reset | flush;
      pushFire      = push & ~full & ~hold;
      popFire       = pop & popValid & ~hold;
      wrPtrInc      = (wrPtr == LAST_ADDR) ? '0 : wrPtr + 1'b1;
      rdPtrInc      = (rdPtr == LAST_ADDR) ? '0 : rdPtr + 1'b1;
      countAfterPop = count - (ADDRESSWIDTH + 1)'(popFire);
      countNext     = countAfterPop + (ADDRESSWIDTH + 1)'(pushFire);
      // Look ahead one entry on a pop so the RAM presents the new head next cycle.
      if (hold) begin
         memReadAddress = '0;
      end else if (popFire) begin
         memReadAddress = rdPtrInc;
      end else begin
         memReadAddress = rdPtr;
      end
   end

   assign memWriteEn      = pushFire;
   assign memDataIn       = pushData;
   assign memWriteAddress = wrPtr;
   assign popData         = memDataOut;
   assign full            = (count == DEPTH_C);
   assign empty           = (count == '0);

   always_ff @(posedge clk) begin
      if (hold) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         popValid <= 1'b0;
      end else begin
         if (pushFire) wrPtr <= wrPtrInc;
         if (popFire)  rdPtr <= rdPtrInc;
         count    <= countNext;
         // A word written this cycle is not yet readable, so only pre-existing entries count.
         popValid <= (countAfterPop != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push & full & ~flush) begin
            overflow <= 1'b1;
         end else if (errClear) begin
            overflow <= 1'b0;
         end
         if (pop & ~popValid & ~flush) begin
            underflow <= 1'b1;
         end else if (errClear) begin
            underflow <= 1'b0;
         end
      end
   end

`ifdef SPI_FIFO_LEVEL_FLAGS_EN
   localparam logic [ADDRESSWIDTH:0] AFULL_C  = (ADDRESSWIDTH + 1)'(AFULLLEVEL);
   localparam logic [ADDRESSWIDTH:0] AEMPTY_C = (ADDRESSWIDTH + 1)'(AEMPTYLEVEL);

   always_ff @(posedge clk) begin
      if (hold) begin
         almostFull  <= 1'b0;
         almostEmpty <= 1'b1;
      end else begin
         almostFull  <= (countNext >= AFULL_C);
         almostEmpty <= (countNext <= AEMPTY_C);
      end
   end
`endif

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// Scoreboard bench for spi_fifo_ctrl with a behavioural 1-cycle-latency RAM.
// Level-flag vectors run on a second DEPTH=8 instance when SPI_FIFO_LEVEL_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_spi_fifo_ctrl;
   localparam int DW = 8;
   localparam int DD = 4;
   localparam int AW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, flush, errClear, push, pop;
   logic [DW-1:0] pushData, popData, memDataIn, memDataOut;
   logic          popValid, full, empty, overflow, underflow, memWriteEn;
   logic [AW:0]   count;
   logic [AW-1:0] memWriteAddress, memReadAddress;
   logic [DW-1:0] ram [DD];

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_word;

`ifdef SPI_FIFO_LEVEL_FLAGS_EN
   logic          afDummy, aeDummy;
`endif

   spi_fifo_ctrl #(.DATAWIDTH(DW), .DATADEPTH(DD)) dut (
      .clk(clk), .reset(reset), .flush(flush), .errClear(errClear),
      .push(push), .pushData(pushData), .pop(pop), .popData(popData),
      .popValid(popValid), .full(full), .empty(empty), .count(count),
      .overflow(overflow), .underflow(underflow), .memWriteEn(memWriteEn),
      .memDataIn(memDataIn), .memWriteAddress(memWriteAddress),
      .memReadAddress(memReadAddress), .memDataOut(memDataOut)
`ifdef SPI_FIFO_LEVEL_FLAGS_EN
      , .almostFull(afDummy), .almostEmpty(aeDummy)
`endif
   );

   always @(posedge clk) begin
      if (memWriteEn) ram[memWriteAddress] <= memDataIn;
      memDataOut <= ram[memReadAddress];
   end

`ifdef SPI_FIFO_LEVEL_FLAGS_EN
   logic          lPush;
   logic [DW-1:0] lPushData, lPopData, lMemDataIn, lMemDataOut;
   logic          lPopValid, lFull, lEmpty, lOverflow, lUnderflow, lMemWriteEn;
   logic          lAlmostFull, lAlmostEmpty;
   logic [3:0]    lCount;
   logic [2:0]    lMemWriteAddress, lMemReadAddress;
   logic [DW-1:0] lram [8];

   spi_fifo_ctrl #(.DATAWIDTH(DW), .DATADEPTH(8), .AFULLLEVEL(6), .AEMPTYLEVEL(1)) dut_lvl (
      .clk(clk), .reset(reset), .flush(1'b0), .errClear(1'b0),
      .push(lPush), .pushData(lPushData), .pop(1'b0), .popData(lPopData),
      .popValid(lPopValid), .full(lFull), .empty(lEmpty), .count(lCount),
      .overflow(lOverflow), .underflow(lUnderflow), .memWriteEn(lMemWriteEn),
      .memDataIn(lMemDataIn), .memWriteAddress(lMemWriteAddress),
      .memReadAddress(lMemReadAddress), .memDataOut(lMemDataOut),
      .almostFull(lAlmostFull), .almostEmpty(lAlmostEmpty)
   );

   always @(posedge clk) begin
      if (lMemWriteEn) lram[lMemWriteAddress] <= lMemDataIn;
      lMemDataOut <= lram[lMemReadAddress];
   end
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] d, input bit expect_store);
      push     = 1'b1;
      pushData = d;
      if (expect_store) exp_q.push_back(d);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; errClear = 1'b0;
      push = 1'b0; pop = 1'b0; pushData = '0;
`ifdef SPI_FIFO_LEVEL_FLAGS_EN
      lPush = 1'b0; lPushData = '0;
`endif

      fork
         forever begin
            @(negedge clk);
            if (pop && popValid && !reset && !flush) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL pop_unexpected: got 0x%0h with empty scoreboard", popData);
               end else begin
                  exp_word = exp_q.pop_front();
                  chk("pop_data", popData, exp_word);
               end
            end
         end
      join_none

      tick(); tick();
      reset = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_popValid", popValid, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_underflow", underflow, 0);

      // Push into empty: popValid two cycles later
      push_word(8'hA5, 1'b1);
      push = 1'b0;
      chk("t1_count", count, 1);
      chk("t1_empty", empty, 0);
      chk("t1_popValid_c1", popValid, 0);
      tick();
      chk("t1_popValid_c2", popValid, 1);
      chk("t1_popData_c2", popData, 8'hA5);
      pop = 1'b1; tick(); pop = 1'b0;
      chk("t1_popValid_after", popValid, 0);
      chk("t1_empty_after", empty, 1);

      // Fill, overflow, order
      for (int i = 1; i <= 4; i++) push_word(DW'(i), 1'b1);
      push_word(8'd5, 1'b0);
      push = 1'b0;
      chk("t2_full", full, 1);
      chk("t2_count", count, 4);
      chk("t2_overflow", overflow, 1);
      pop = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      pop = 1'b0;
      chk("t2_popValid_end", popValid, 0);
      chk("t2_empty_end", empty, 1);
      chk("t2_count_end", count, 0);

      // Wrap-around with simultaneous push and pop
      push_word(8'd10, 1'b1);
      push_word(8'd11, 1'b1);
      push = 1'b0;
      tick();
      chk("t3_count_start", count, 2);
      pop = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push_word(DW'(12 + i), 1'b1);
         chk("t3_count_steady", count, 2);
      end
      push = 1'b0;
      tick(); tick();
      pop = 1'b0;
      #1;
      chk("t3_empty", empty, 1);
      chk("t3_wrPtr_wrapped", memWriteAddress, 1);
      chk("t3_rdPtr_wrapped", memReadAddress, 1);

      // Underflow and flag clearing
      errClear = 1'b1; tick(); errClear = 1'b0;
      chk("t4_overflow_cleared", overflow, 0);
      pop = 1'b1; tick(); pop = 1'b0;
      #1;
      chk("t4_underflow_set", underflow, 1);
      chk("t4_rdPtr_unchanged", memReadAddress, 1);
      chk("t4_count", count, 0);
      errClear = 1'b1; tick(); errClear = 1'b0;
      chk("t4_underflow_cleared", underflow, 0);
      errClear = 1'b1; pop = 1'b1; tick(); errClear = 1'b0; pop = 1'b0;
      chk("t4_set_wins", underflow, 1);

      // Flush mid-operation
      push_word(8'd20, 1'b1);
      push_word(8'd21, 1'b1);
      push_word(8'd22, 1'b1);
      push = 1'b0;
      tick();
      chk("t5_count_before", count, 3);
      flush = 1'b1; push = 1'b1; pushData = 8'd99; pop = 1'b1;
      #1;
      chk("t5_memWriteEn_flush", memWriteEn, 0);
      chk("t5_memReadAddress_flush", memReadAddress, 0);
      exp_q.delete();
      tick();
      flush = 1'b0; push = 1'b0; pop = 1'b0;
      chk("t5_count", count, 0);
      chk("t5_popValid", popValid, 0);
      chk("t5_empty", empty, 1);
      chk("t5_overflow_kept", overflow, 0);
      chk("t5_underflow_kept", underflow, 1);
      push_word(8'd30, 1'b1);
      push = 1'b0;
      chk("t5_popValid_c1", popValid, 0);
      tick();
      chk("t5_popValid_c2", popValid, 1);
      chk("t5_popData_c2", popData, 8'd30);
      pop = 1'b1; tick(); pop = 1'b0;
      chk("t5_empty_end", empty, 1);

`ifdef SPI_FIFO_LEVEL_FLAGS_EN
      // Level flags on the DEPTH=8 instance
      chk("t6_rst_almostFull", lAlmostFull, 0);
      chk("t6_rst_almostEmpty", lAlmostEmpty, 1);
      lPush = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         lPushData = DW'(i);
         tick();
         chk("t6_almostEmpty", lAlmostEmpty, (i <= 1) ? 1 : 0);
         chk("t6_almostFull", lAlmostFull, (i >= 6) ? 1 : 0);
      end
      lPush = 1'b0;
`endif

      tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
